// File: rtl/tl_source_compactor_if.sv
// TL-UL channel bundle (A request, D response) shared by host and device sides.
// The master drives A and consumes D; the slave does the reverse.
interface tl_source_compactor_if #(
  parameter int unsigned SourceWidth = 8,
  parameter int unsigned AddrWidth   = 56,
  parameter int unsigned DataWidth   = 64,
  parameter int unsigned SizeWidth   = 3,
  parameter int unsigned SinkWidth   = 1
);
  localparam int unsigned MaskWidth = DataWidth / 8;

  logic                   a_valid;
  logic                   a_ready;
  logic [2:0]             a_opcode;
  logic [2:0]             a_param;
  logic [SizeWidth-1:0]   a_size;
  logic [SourceWidth-1:0] a_source;
  logic [AddrWidth-1:0]   a_address;
  logic [MaskWidth-1:0]   a_mask;
  logic                   a_corrupt;
  logic [DataWidth-1:0]   a_data;

  logic                   d_valid;
  logic                   d_ready;
  logic [2:0]             d_opcode;
  logic [1:0]             d_param;
  logic [SizeWidth-1:0]   d_size;
  logic [SourceWidth-1:0] d_source;
  logic [SinkWidth-1:0]   d_sink;
  logic                   d_denied;
  logic                   d_corrupt;
  logic [DataWidth-1:0]   d_data;

  modport master (
    output a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_corrupt, a_data,
    input  a_ready,
    input  d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_corrupt, d_data,
    output d_ready
  );

  modport slave (
    input  a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_corrupt, a_data,
    output a_ready,
    output d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_corrupt, d_data,
    input  d_ready
  );
endinterface

// File: rtl/tl_source_compactor.sv
// Maps a sparse host source-ID space onto a small pool of device source IDs.
// A allocates the lowest free slot on a first beat; the last D beat releases it.
module tl_source_compactor #(
  parameter int unsigned HostSourceWidth   = 8,
  parameter int unsigned DeviceSourceWidth = 2,
  parameter int unsigned AddrWidth         = 56,
  parameter int unsigned DataWidth         = 64,
  parameter int unsigned SizeWidth         = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  tl_source_compactor_if.slave  host,
  tl_source_compactor_if.master device,
  output logic                  idle_o
);

  localparam int unsigned NumSlots  = 2 ** DeviceSourceWidth;
  localparam int unsigned BeatBytes = DataWidth / 8;
  localparam int unsigned LgBeat    = $clog2(BeatBytes);
  localparam int unsigned CntWidth  = (2 ** SizeWidth) + 1;

  typedef logic [DeviceSourceWidth-1:0] slot_t;
  typedef logic [CntWidth-1:0]          cnt_t;
  typedef logic [HostSourceWidth-1:0]   hsrc_t;

  typedef enum logic [2:0] {
    A_PUT_FULL    = 3'd0,
    A_PUT_PARTIAL = 3'd1,
    A_ARITHMETIC  = 3'd2,
    A_LOGICAL     = 3'd3,
    A_GET         = 3'd4,
    A_INTENT      = 3'd5
  } a_opcode_e;

  typedef enum logic [2:0] {
    D_ACCESS_ACK      = 3'd0,
    D_ACCESS_ACK_DATA = 3'd1,
    D_HINT_ACK        = 3'd2
  } d_opcode_e;

  // Beats beyond the first: only data-carrying messages wider than one beat burst.
  function automatic cnt_t extra_beats(input logic has_data, input logic [SizeWidth-1:0] size);
    cnt_t n;
    n = '0;
    if (has_data && (int'(size) > int'(LgBeat))) begin
      n = (cnt_t'(1) << (int'(size) - int'(LgBeat))) - cnt_t'(1);
    end
    return n;
  endfunction

  // Gates the A path until the first clock after reset release.
  logic                run_q;
  logic [NumSlots-1:0] slot_valid_q, slot_valid_d;
  logic                a_active_q, a_active_d;
  slot_t               a_slot_q, a_slot_d;
  cnt_t                a_beats_left_q, a_beats_left_d;
  cnt_t                d_cnt_q [NumSlots];
  cnt_t                d_cnt_d [NumSlots];
  hsrc_t               slot_src_q [NumSlots];

  logic  any_free;
  slot_t free_slot;
  logic  a_open;
  logic  a_fire;
  logic  a_alloc;
  logic  a_has_data;
  cnt_t  a_extra;
  logic  d_fire;
  logic  d_last;
  cnt_t  d_extra;

  // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
  always_comb begin
    any_free  = 1'b0;
    free_slot = '0;
    for (int i = NumSlots - 1; i >= 0; i--) begin
      if (!slot_valid_q[i]) begin
        any_free  = 1'b1;
        free_slot = slot_t'(i);
      end
    end
  end

  assign a_has_data = host.a_opcode inside {A_PUT_FULL, A_PUT_PARTIAL, A_ARITHMETIC, A_LOGICAL};
  assign a_extra    = extra_beats(a_has_data, host.a_size);
  assign a_open     = run_q & (a_active_q | any_free);
  assign a_fire     = host.a_valid & device.a_ready & a_open;
  assign a_alloc    = a_fire & ~a_active_q;

  assign device.a_valid   = host.a_valid & a_open;
  assign host.a_ready     = device.a_ready & a_open;
  assign device.a_source  = a_active_q ? a_slot_q : free_slot;
  assign device.a_opcode  = host.a_opcode;
  assign device.a_param   = host.a_param;
  assign device.a_size    = host.a_size;
  assign device.a_address = host.a_address;
  assign device.a_mask    = host.a_mask;
  assign device.a_corrupt = host.a_corrupt;
  assign device.a_data    = host.a_data;

  assign d_extra = extra_beats(device.d_opcode == D_ACCESS_ACK_DATA, device.d_size);
  assign d_fire  = device.d_valid & host.d_ready;
  assign d_last  = (d_cnt_q[device.d_source] == d_extra);

  assign host.d_valid   = device.d_valid;
  assign device.d_ready = host.d_ready;
  assign host.d_source  = slot_src_q[device.d_source];
  assign host.d_opcode  = device.d_opcode;
  assign host.d_param   = device.d_param;
  assign host.d_size    = device.d_size;
  assign host.d_sink    = device.d_sink;
  assign host.d_denied  = device.d_denied;
  assign host.d_corrupt = device.d_corrupt;
  assign host.d_data    = device.d_data;

  assign idle_o = ~|slot_valid_q & ~a_active_q;

  // NOTE: combinational next-state uses blocking '='; the registers below use '<=' only.
  always_comb begin
    slot_valid_d   = slot_valid_q;
    a_active_d     = a_active_q;
    a_slot_d       = a_slot_q;
    a_beats_left_d = a_beats_left_q;
    d_cnt_d        = d_cnt_q;

    if (a_fire) begin
      if (a_active_q) begin
        a_beats_left_d = a_beats_left_q - cnt_t'(1);
        if (a_beats_left_q == cnt_t'(1)) begin
          a_active_d = 1'b0;
        end
      end else begin
        slot_valid_d[free_slot] = 1'b1;
        if (a_extra != '0) begin
          a_active_d     = 1'b1;
          a_slot_d       = free_slot;
          a_beats_left_d = a_extra;
        end
      end
    end

    // A slot released here was valid this cycle, so it never collides with the allocation above.
    if (d_fire) begin
      if (d_last) begin
        slot_valid_d[device.d_source] = 1'b0;
        d_cnt_d[device.d_source]      = '0;
      end else begin
        d_cnt_d[device.d_source] = d_cnt_q[device.d_source] + cnt_t'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      run_q          <= 1'b0;
      slot_valid_q   <= '0;
      a_active_q     <= 1'b0;
      a_slot_q       <= '0;
      a_beats_left_q <= '0;
      d_cnt_q        <= '{default: '0};
    end else begin
      run_q          <= 1'b1;
      slot_valid_q   <= slot_valid_d;
      a_active_q     <= a_active_d;
      a_slot_q       <= a_slot_d;
      a_beats_left_q <= a_beats_left_d;
      d_cnt_q        <= d_cnt_d;
    end
  end

  // NOTE: the source table has no reset; an entry is only read while its slot_valid bit is set.
  always_ff @(posedge clk_i) begin
    if (a_alloc) begin
      slot_src_q[free_slot] <= host.a_source;
    end
  end

  d_source_allocated: assert property (
    @(posedge clk_i) disable iff (!rst_ni) device.d_valid |-> slot_valid_q[device.d_source]
  );

endmodule

// File: tb/tb_tl_source_compactor.sv
// Bench for tl_source_compactor: directed scenarios plus a randomized run, all
// checked against a slot-pool model kept in plain bench variables.
module tb_tl_source_compactor;

  localparam logic [2:0] PUT_FULL = 3'd0;
  localparam logic [2:0] GET      = 3'd4;
  localparam logic [2:0] ACK      = 3'd0;
  localparam logic [2:0] ACK_DATA = 3'd1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic idle;
  int   errors = 0;
  int   checks = 0;

  tl_source_compactor_if #(.SourceWidth(8)) host ();
  tl_source_compactor_if #(.SourceWidth(2)) dev ();

  tl_source_compactor #(
    .HostSourceWidth(8), .DeviceSourceWidth(2), .AddrWidth(56), .DataWidth(64), .SizeWidth(3)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .host(host), .device(dev), .idle_o(idle)
  );

  always #5 clk = ~clk;

  // Model: a pool of four IDs, each owned by a host source while in flight.
  bit         m_valid [4];
  logic [7:0] m_src   [4];
  int         m_dcnt  [4];
  bit         m_act;
  int         m_slot;
  int         m_left;
  bit         m_en;
  bit         last_a_fire;
  bit         last_d_fire;

  function automatic int beats_of(input bit has_data, input int size);
    return (has_data && size > 3) ? (1 << (size - 3)) : 1;
  endfunction

  function automatic int m_free();
    for (int i = 0; i < 4; i++) if (!m_valid[i]) return i;
    return -1;
  endfunction

  function automatic bit exp_open();
    return m_en && (m_act || m_free() >= 0);
  endfunction

  function automatic int exp_a_src();
    return m_act ? m_slot : m_free();
  endfunction

  function automatic bit exp_idle();
    for (int i = 0; i < 4; i++) if (m_valid[i]) return 1'b0;
    return !m_act;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 4; i++) begin m_valid[i] = 0; m_dcnt[i] = 0; end
    m_act = 0; m_slot = 0; m_left = 0; m_en = 0;
  endtask

  task automatic set_a(input bit v, input logic [2:0] op, input int size, input logic [7:0] src);
    host.a_valid   = v;
    host.a_opcode  = op;
    host.a_param   = 3'd0;
    host.a_size    = 3'(size);
    host.a_source  = src;
    host.a_address = 56'({$urandom(), $urandom()});
    host.a_mask    = 8'hFF;
    host.a_corrupt = 1'b0;
    host.a_data    = {$urandom(), $urandom()};
  endtask

  task automatic set_d(input bit v, input logic [2:0] op, input int size, input int slot);
    dev.d_valid   = v;
    dev.d_opcode  = op;
    dev.d_param   = 2'd0;
    dev.d_size    = 3'(size);
    dev.d_source  = 2'(slot);
    dev.d_sink    = 1'b0;
    dev.d_denied  = 1'b0;
    dev.d_corrupt = 1'b0;
    dev.d_data    = {$urandom(), $urandom()};
  endtask

  // Apply this cycle's handshakes to the model, then advance to the next falling edge.
  task automatic step();
    int fs;
    int nb;
    int sl;
    last_a_fire = 0;
    last_d_fire = 0;
    fs = m_free();
    if (rst_n) begin
      if (host.a_valid && dev.a_ready && exp_open()) begin
        last_a_fire = 1;
        if (m_act) begin
          m_left--;
          if (m_left == 0) m_act = 0;
        end else begin
          m_valid[fs] = 1;
          m_src[fs]   = host.a_source;
          nb = beats_of(host.a_opcode < 3'd4, int'(host.a_size));
          if (nb > 1) begin m_act = 1; m_slot = fs; m_left = nb - 1; end
        end
      end
      if (dev.d_valid && host.d_ready) begin
        last_d_fire = 1;
        sl = int'(dev.d_source);
        m_dcnt[sl]++;
        if (m_dcnt[sl] == beats_of(dev.d_opcode == ACK_DATA, int'(dev.d_size))) begin
          m_valid[sl] = 0;
          m_dcnt[sl]  = 0;
        end
      end
    end
    @(posedge clk);
    if (rst_n) m_en = 1;
    @(negedge clk);
  endtask

  task automatic drain();
    int guard;
    int sl;
    set_a(0, GET, 0, 8'h00);
    host.d_ready = 1'b1;
    guard = 0;
    while (!exp_idle() && guard < 64) begin
      sl = 0;
      for (int i = 3; i >= 0; i--) if (m_valid[i]) sl = i;
      set_d(1, ACK, 0, sl);
      step();
      guard++;
    end
    set_d(0, ACK, 0, 0);
    checks++; if (!exp_idle()) begin errors++; $display("FAIL drain_timeout: table still busy after %0d cycles", guard); end
  endtask

  task automatic test_reset();
    model_clear();
    rst_n = 1'b0;
    set_a(1, GET, 3, 8'h01);
    set_d(1, ACK, 0, 0);
    dev.a_ready  = 1'b1;
    host.d_ready = 1'b1;
    #1;
    checks++; if (dev.a_valid !== 1'b0) begin errors++; $display("FAIL rst_dav: got %b want 0", dev.a_valid); end
    checks++; if (host.a_ready !== 1'b0) begin errors++; $display("FAIL rst_har: got %b want 0", host.a_ready); end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL rst_idle: got %b want 1", idle); end
    checks++; if (host.d_valid !== 1'b1) begin errors++; $display("FAIL rst_hdv1: got %b want 1", host.d_valid); end
    checks++; if (dev.d_ready !== 1'b1) begin errors++; $display("FAIL rst_ddr: got %b want 1", dev.d_ready); end
    @(negedge clk);
    set_d(0, ACK, 0, 0);
    set_a(0, GET, 3, 8'h01);
    #1;
    checks++; if (host.d_valid !== 1'b0) begin errors++; $display("FAIL rst_hdv0: got %b want 0", host.d_valid); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (host.a_ready !== 1'b0) begin errors++; $display("FAIL rst_rel_har: got %b want 0", host.a_ready); end
    step();
    #1;
    checks++; if (host.a_ready !== 1'b1) begin errors++; $display("FAIL run_har: got %b want 1", host.a_ready); end
    checks++; if (dev.a_valid !== 1'b0) begin errors++; $display("FAIL run_dav: got %b want 0", dev.a_valid); end
  endtask

  task automatic test_single_get();
    set_a(1, GET, 3, 8'hA5);
    #1;
    checks++; if (dev.a_valid !== 1'b1) begin errors++; $display("FAIL t1_dav: got %b want 1", dev.a_valid); end
    checks++; if (dev.a_source !== 2'd0) begin errors++; $display("FAIL t1_das: got %0d want 0", dev.a_source); end
    step();
    set_a(0, GET, 3, 8'h00);
    #1;
    checks++; if (idle !== 1'b0) begin errors++; $display("FAIL t1_busy: got %b want 0", idle); end
    set_d(1, ACK_DATA, 3, 0);
    #1;
    checks++; if (host.d_source !== 8'hA5) begin errors++; $display("FAIL t1_hds: got %h want a5", host.d_source); end
    step();
    set_d(0, ACK, 0, 0);
    #1;
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL t1_idle: got %b want 1", idle); end
  endtask

  task automatic test_fill_and_stall();
    for (int i = 0; i < 4; i++) begin
      set_a(1, GET, 3, 8'((i + 1) * 16));
      #1;
      checks++; if (dev.a_source !== 2'(i) || dev.a_valid !== 1'b1) begin errors++; $display("FAIL t2_fill%0d: got v=%b src=%0d want v=1 src=%0d", i, dev.a_valid, dev.a_source, i); end
      step();
    end
    set_a(1, GET, 3, 8'h50);
    #1;
    checks++; if (host.a_ready !== 1'b0 || dev.a_valid !== 1'b0) begin errors++; $display("FAIL t2_full: got rdy=%b v=%b want 0 0", host.a_ready, dev.a_valid); end
    step();
    set_d(1, ACK, 2, 2);
    #1;
    checks++; if (dev.a_valid !== 1'b0) begin errors++; $display("FAIL t2_same_cycle: got %b want 0", dev.a_valid); end
    checks++; if (host.d_source !== 8'h30) begin errors++; $display("FAIL t2_hds: got %h want 30", host.d_source); end
    step();
    set_d(0, ACK, 0, 0);
    #1;
    checks++; if (dev.a_valid !== 1'b1 || dev.a_source !== 2'd2) begin errors++; $display("FAIL t2_reissue: got v=%b src=%0d want v=1 src=2", dev.a_valid, dev.a_source); end
    step();
    drain();
  endtask

  task automatic test_burst_last_slot();
    int beat;
    for (int i = 0; i < 3; i++) begin set_a(1, GET, 3, 8'(i)); step(); end
    beat = 0;
    for (int c = 0; c < 8 && beat < 4; c++) begin
      dev.a_ready = (c != 2);
      set_a(1, PUT_FULL, 5, 8'h7F);
      #1;
      checks++; if (dev.a_valid !== 1'b1 || dev.a_source !== 2'd3) begin errors++; $display("FAIL t3_beat%0d: got v=%b src=%0d want v=1 src=3", beat, dev.a_valid, dev.a_source); end
      checks++; if (host.a_ready !== dev.a_ready) begin errors++; $display("FAIL t3_rdy%0d: got %b want %b", c, host.a_ready, dev.a_ready); end
      step();
      if (last_a_fire) beat++;
    end
    dev.a_ready = 1'b1;
    checks++; if (beat != 4) begin errors++; $display("FAIL t3_beats: got %0d want 4", beat); end
    set_a(1, GET, 3, 8'h01);
    #1;
    checks++; if (host.a_ready !== 1'b0) begin errors++; $display("FAIL t3_full: got %b want 0", host.a_ready); end
    set_a(0, GET, 3, 8'h01);
    set_d(1, ACK, 5, 3);
    #1;
    checks++; if (host.d_source !== 8'h7F) begin errors++; $display("FAIL t3_hds: got %h want 7f", host.d_source); end
    step();
    drain();
  endtask

  task automatic test_multibeat_d();
    int fired;
    set_a(1, GET, 3, 8'h11); step();
    set_a(1, GET, 6, 8'h22); step();
    set_a(0, GET, 3, 8'h00);
    set_d(1, ACK, 0, 0); step();
    fired = 0;
    for (int c = 0; c < 40 && fired < 8; c++) begin
      host.d_ready = (c % 3 != 1);
      set_d(1, ACK_DATA, 6, 1);
      #1;
      checks++; if (host.d_source !== 8'h22) begin errors++; $display("FAIL t4_hds: got %h want 22", host.d_source); end
      checks++; if (dev.d_ready !== host.d_ready) begin errors++; $display("FAIL t4_ddr: got %b want %b", dev.d_ready, host.d_ready); end
      checks++; if (idle !== 1'b0) begin errors++; $display("FAIL t4_held%0d: idle got %b want 0", fired, idle); end
      step();
      if (last_d_fire) fired++;
    end
    set_d(0, ACK, 0, 0);
    host.d_ready = 1'b1;
    #1;
    checks++; if (fired != 8) begin errors++; $display("FAIL t4_beats: got %0d want 8", fired); end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL t4_freed: idle got %b want 1", idle); end
  endtask

  task automatic test_same_cycle_free();
    for (int i = 0; i < 4; i++) begin set_a(1, GET, 3, 8'(8'h60 + i)); step(); end
    set_a(1, GET, 3, 8'h66);
    set_d(1, ACK, 0, 0);
    #1;
    checks++; if (dev.a_valid !== 1'b0 || host.a_ready !== 1'b0) begin errors++; $display("FAIL t5_block: got v=%b rdy=%b want 0 0", dev.a_valid, host.a_ready); end
    step();
    set_d(0, ACK, 0, 0);
    #1;
    checks++; if (dev.a_valid !== 1'b1 || dev.a_source !== 2'd0) begin errors++; $display("FAIL t5_next: got v=%b src=%0d want v=1 src=0", dev.a_valid, dev.a_source); end
    step();
    drain();
  endtask

  task automatic test_reset_midburst();
    set_a(1, GET, 3, 8'h01); step();
    set_a(1, GET, 3, 8'h02); step();
    set_a(1, PUT_FULL, 5, 8'h03); step();
    rst_n = 1'b0;
    model_clear();
    set_d(1, ACK, 0, 2);
    #1;
    checks++; if (dev.a_valid !== 1'b0) begin errors++; $display("FAIL t6_dav: got %b want 0", dev.a_valid); end
    checks++; if (host.d_valid !== 1'b1) begin errors++; $display("FAIL t6_hdv: got %b want 1", host.d_valid); end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL t6_idle: got %b want 1", idle); end
    set_d(0, ACK, 0, 0);
    set_a(0, GET, 3, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    set_a(1, GET, 3, 8'h99);
    #1;
    checks++; if (dev.a_valid !== 1'b1 || dev.a_source !== 2'd0) begin errors++; $display("FAIL t6_after: got v=%b src=%0d want v=1 src=0", dev.a_valid, dev.a_source); end
    step();
    drain();
  endtask

  task automatic test_random();
    logic [2:0] cur_op;
    int         cur_size;
    logic [7:0] cur_src;
    bit         d_busy;
    int         d_slot;
    logic [2:0] d_op;
    int         d_size;
    int         cand;
    bit         go;
    cur_op = GET; cur_size = 0; cur_src = 8'h00;
    d_busy = 0; d_slot = 0; d_op = ACK; d_size = 0;
    for (int c = 0; c < 400; c++) begin
      if (!m_act) begin
        cur_op   = ($urandom_range(0, 1) != 0) ? GET : PUT_FULL;
        cur_size = $urandom_range(0, 5);
        cur_src  = 8'($urandom());
      end
      set_a($urandom_range(0, 3) != 0, cur_op, cur_size, cur_src);
      dev.a_ready = ($urandom_range(0, 3) != 0);
      if (!d_busy && $urandom_range(0, 1) != 0) begin
        cand = -1;
        for (int k = 0; k < 4; k++) begin
          int s;
          s = (c + k) % 4;
          if (cand < 0 && m_valid[s] && !(m_act && m_slot == s)) cand = s;
        end
        if (cand >= 0) begin
          d_busy = 1; d_slot = cand;
          d_op   = ($urandom_range(0, 1) != 0) ? ACK_DATA : ACK;
          d_size = $urandom_range(0, 5);
        end
      end
      set_d(d_busy && $urandom_range(0, 3) != 0, d_op, d_size, d_slot);
      host.d_ready = ($urandom_range(0, 3) != 0);
      #1;
      go = exp_open();
      checks++; if (dev.a_valid !== (host.a_valid & go)) begin errors++; $display("FAIL rnd_dav c=%0d: got %b want %b", c, dev.a_valid, host.a_valid & go); end
      checks++; if (host.a_ready !== (dev.a_ready & go)) begin errors++; $display("FAIL rnd_har c=%0d: got %b want %b", c, host.a_ready, dev.a_ready & go); end
      if (host.a_valid && go) begin
        checks++; if (dev.a_source !== 2'(exp_a_src())) begin errors++; $display("FAIL rnd_das c=%0d: got %0d want %0d", c, dev.a_source, exp_a_src()); end
      end
      checks++; if (dev.a_data !== host.a_data || dev.a_address !== host.a_address) begin errors++; $display("FAIL rnd_apay c=%0d: got %h want %h", c, dev.a_data, host.a_data); end
      checks++; if (host.d_valid !== dev.d_valid || dev.d_ready !== host.d_ready) begin errors++; $display("FAIL rnd_dhs c=%0d: got v=%b r=%b want v=%b r=%b", c, host.d_valid, dev.d_ready, dev.d_valid, host.d_ready); end
      if (dev.d_valid) begin
        checks++; if (host.d_source !== m_src[d_slot]) begin errors++; $display("FAIL rnd_hds c=%0d: got %h want %h", c, host.d_source, m_src[d_slot]); end
      end
      checks++; if (idle !== exp_idle()) begin errors++; $display("FAIL rnd_idle c=%0d: got %b want %b", c, idle, exp_idle()); end
      step();
      if (d_busy && !m_valid[d_slot]) d_busy = 0;
    end
    while (m_act) begin
      set_a(1, cur_op, cur_size, cur_src);
      dev.a_ready = 1'b1;
      set_d(0, ACK, 0, 0);
      step();
    end
    if (d_busy) begin
      host.d_ready = 1'b1;
      for (int g = 0; g < 32 && m_valid[d_slot]; g++) begin
        set_a(0, GET, 0, 8'h00);
        set_d(1, d_op, d_size, d_slot);
        step();
      end
    end
    drain();
  endtask

  initial begin
    set_a(0, GET, 0, 8'h00);
    set_d(0, ACK, 0, 0);
    dev.a_ready  = 1'b1;
    host.d_ready = 1'b1;
    test_reset();
    test_single_get();
    test_fill_and_stall();
    test_burst_last_slot();
    test_multibeat_d();
    test_same_cycle_free();
    test_reset_midburst();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
